// File: rtl/cascade_ack_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cascade_ack_sequencer_if
// Description : Bundles the configuration, priority-resolver, cascade and
//               data-bus signals of the 8259-style acknowledge sequencer.
//               modport slave  : view taken by the sequencer itself
//               modport master : view taken by whatever drives the sequencer
// Ports       : none (clock and reset stay plain ports on the sequencer)
// Revision    : 1.0 - initial release
// ============================================================================
interface cascade_ack_sequencer_if;
    logic       interrupt_acknowledge_n;
    logic       u8086_mode;
    logic       single_or_cascade_config;
    logic       slave_program_n;
    logic [7:0] cascade_device_config;
    logic       interrupt_valid;
    logic [2:0] highest_level;
    logic [4:0] vector_t7_t3;
    logic [2:0] address_a7_a5;
    logic [7:0] address_a15_a8;
    logic [2:0] cascade_in;
    logic [2:0] cascade_out;
    logic       cascade_out_enable;
    logic [7:0] data_out;
    logic       data_out_enable;
    logic       latch_in_service;
    logic       end_of_acknowledge;
    logic [1:0] control_state;

    modport slave (
        input  interrupt_acknowledge_n, u8086_mode, single_or_cascade_config,
               slave_program_n, cascade_device_config, interrupt_valid,
               highest_level, vector_t7_t3, address_a7_a5, address_a15_a8,
               cascade_in,
        output cascade_out, cascade_out_enable, data_out, data_out_enable,
               latch_in_service, end_of_acknowledge, control_state
    );

    modport master (
        output interrupt_acknowledge_n, u8086_mode, single_or_cascade_config,
               slave_program_n, cascade_device_config, interrupt_valid,
               highest_level, vector_t7_t3, address_a7_a5, address_a15_a8,
               cascade_in,
        input  cascade_out, cascade_out_enable, data_out, data_out_enable,
               latch_in_service, end_of_acknowledge, control_state
    );
endinterface
`default_nettype wire

// File: rtl/cascade_ack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cascade_ack_sequencer
// Description : INTA# acknowledge sequencer of an 8259-style interrupt
//               controller. Tracks the two (8086) or three (8080) INTA#
//               pulses, captures the winning level, drives CAS2-0 as a
//               cascade master and places the vector bytes on the data bus.
// Ports       : clock    - single clock, state updates on its falling edge
//               reset_n  - synchronous active-low reset
//               bus      - cascade_ack_sequencer_if.slave: INTA#, ICW
//                          configuration, resolver winner, vector fields,
//                          CAS in/out, data bus drive, pulses, state
// Revision    : 1.0 - initial release
// ============================================================================
module cascade_ack_sequencer (
    input  wire logic              clock,
    input  wire logic              reset_n,
    cascade_ack_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_ACK1  = 2'd1,
        ST_ACK2  = 2'd2,
        ST_ACK3  = 2'd3
    } state_t;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;  // 8080 CALL instruction
    localparam logic [2:0] SPURIOUS_LEVEL = 3'b111;

    state_t     state_q, state_d;
    logic       inta_prev_q;
    logic [2:0] level_q, level_d;
    logic       selected_q, selected_d;

    logic       inta_fall, inta_rise;
    logic       is_master, cascade_mode, slave_target, drive_owner;
    logic       lis_c, eoa_c;
    logic [7:0] data_c;
    logic       data_en_c;
    logic [2:0] cas_c;
    logic       cas_en_c;

    // ------------------------------------------------------------------
    // State register (falling-edge clocked)
    // ------------------------------------------------------------------
    always_ff @(negedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_READY;
            inta_prev_q <= 1'b1;
            level_q     <= 3'b000;
            selected_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= bus.interrupt_acknowledge_n;
            level_q     <= level_d;
            selected_q  <= selected_d;
        end
    end

    assign inta_fall = inta_prev_q & ~bus.interrupt_acknowledge_n;
    assign inta_rise = ~inta_prev_q & bus.interrupt_acknowledge_n;

    assign is_master    = bus.slave_program_n | bus.single_or_cascade_config;
    assign cascade_mode = ~bus.single_or_cascade_config;
    // The captured level addresses a slave only when its ICW3 bit is set.
    assign slave_target = cascade_mode & is_master & bus.cascade_device_config[level_q];
    // A master yields the bus to the addressed slave; a slave drives only
    // if it recognised its ID on CAS at the first pulse.
    assign drive_owner  = is_master ? ~slave_target : selected_q;

    // ------------------------------------------------------------------
    // Next-state logic and acknowledge pulses
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        selected_d = selected_q;
        lis_c      = 1'b0;
        eoa_c      = 1'b0;
        case (state_q)
            ST_READY: begin
                if (inta_fall) begin
                    state_d    = ST_ACK1;
                    level_d    = bus.interrupt_valid ? bus.highest_level : SPURIOUS_LEVEL;
                    selected_d = (bus.cascade_in == bus.cascade_device_config[2:0]);
                    lis_c      = bus.interrupt_valid;
                end
            end
            ST_ACK1: begin
                if (inta_fall) begin
                    state_d = ST_ACK2;
                end
            end
            ST_ACK2: begin
                if (bus.u8086_mode) begin
                    if (inta_rise) begin
                        state_d    = ST_READY;
                        selected_d = 1'b0;
                        eoa_c      = 1'b1;
                    end
                end else if (inta_fall) begin
                    state_d = ST_ACK3;
                end
            end
            default: begin  // ST_ACK3: always the last pulse
                if (inta_rise) begin
                    state_d    = ST_READY;
                    selected_d = 1'b0;
                    eoa_c      = 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data bus and CAS drive
    // ------------------------------------------------------------------
    always_comb begin
        data_c    = 8'h00;
        data_en_c = 1'b0;
        if (!bus.interrupt_acknowledge_n) begin
            case (state_q)
                ST_ACK1: begin
                    // The CALL opcode always comes from the master alone.
                    if (!bus.u8086_mode && is_master) begin
                        data_en_c = 1'b1;
                        data_c    = CALL_OPCODE;
                    end
                end
                ST_ACK2: begin
                    if (drive_owner) begin
                        data_en_c = 1'b1;
                        data_c    = bus.u8086_mode ? {bus.vector_t7_t3, level_q}
                                                   : {bus.address_a7_a5, level_q, 2'b00};
                    end
                end
                ST_ACK3: begin
                    if (!bus.u8086_mode && drive_owner) begin
                        data_en_c = 1'b1;
                        data_c    = bus.address_a15_a8;
                    end
                end
                default: begin
                    data_en_c = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cas_c    = 3'b000;
        cas_en_c = 1'b0;
        if (slave_target && (state_q == ST_ACK1 || state_q == ST_ACK2)) begin
            cas_c    = level_q;
            cas_en_c = 1'b1;
        end
    end

    // Outputs are forced low while reset is asserted, even before the
    // reset has been sampled by a clock edge.
    assign bus.control_state      = reset_n ? state_q   : ST_READY;
    assign bus.data_out           = reset_n ? data_c    : 8'h00;
    assign bus.data_out_enable    = reset_n & data_en_c;
    assign bus.cascade_out        = reset_n ? cas_c     : 3'b000;
    assign bus.cascade_out_enable = reset_n & cas_en_c;
    assign bus.latch_in_service   = reset_n & lis_c;
    assign bus.end_of_acknowledge = reset_n & eoa_c;

endmodule
`default_nettype wire
